// File: rtl/jesd204b_dl_pkg.sv
// Shared JESD204B data-link definitions: link-state encoding, control characters
// and the SYNC~ resync threshold calculation.
package jesd204b_dl_pkg;

    typedef enum logic [1:0] {
        LS_DISABLED = 2'b00,
        LS_CGS      = 2'b01,
        LS_ILAS     = 2'b10,
        LS_DATA     = 2'b11
    } link_state_e;

    localparam logic [7:0] K28_5  = 8'hBC;  // /K/ comma
    localparam logic [7:0] ILAS_R = 8'h1C;  // /R/ multiframe start (K28.0)
    localparam logic [7:0] ILAS_A = 8'h7C;  // /A/ multiframe end (K28.3)
    localparam logic [7:0] ILAS_Q = 8'h9C;  // /Q/ config start (K28.4)

    // A SYNC~ low longer than 5 frames + 9 octets is a resync request, in clk beats.
    function automatic int unsigned resync_cycles(input int unsigned octets_per_fr,
                                                  input int unsigned octet_per_sent);
        return (5 * octets_per_fr + 9 + octet_per_sent - 1) / octet_per_sent;
    endfunction

endpackage

// File: rtl/jesd204b_dl_tx_link_ctrl_if.sv
// Control/status bundle between the link controller and its environment.
interface jesd204b_dl_tx_link_ctrl_if;
    logic       enable;
    logic       sync_n;
    logic       lmfc;
    logic [1:0] link_state;
    logic       cgs_en;
    logic       ilas_en;
    logic       data_en;
    logic [3:0] ilas_mf;
    logic       ilas_cfg;
    logic       mark_start;
    logic       err_report;
    logic       resync_evt;
    logic [7:0] err_count;

    modport master (
        output enable, sync_n, lmfc,
        input  link_state, cgs_en, ilas_en, data_en, ilas_mf, ilas_cfg,
               mark_start, err_report, resync_evt, err_count
    );

    modport slave (
        input  enable, sync_n, lmfc,
        output link_state, cgs_en, ilas_en, data_en, ilas_mf, ilas_cfg,
               mark_start, err_report, resync_evt, err_count
    );
endinterface

// File: rtl/jesd204b_dl_sync_monitor.sv
// SYNC~ monitor: registers SYNC~, measures low pulses while the link is up and
// classifies them as error reports (short) or resync requests (long).
module jesd204b_dl_sync_monitor #(
    parameter int unsigned RESYNC_CYCLES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync_n,
    input  logic       active,
    output logic       sync_q,
    output logic       resync_c,
    output logic       err_report,
    output logic       resync_evt,
    output logic [7:0] err_count
);

    localparam int unsigned CNT_W = $clog2(RESYNC_CYCLES + 1);

    logic [CNT_W-1:0] low_cnt;
    logic             err_c;

    // Resync fires on the beat that would bring low_cnt to the threshold.
    assign resync_c = active && !sync_q && (low_cnt == CNT_W'(RESYNC_CYCLES - 1));
    assign err_c    = active && sync_q && (low_cnt != '0)
                      && (low_cnt < CNT_W'(RESYNC_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= 1'b1;
            low_cnt    <= '0;
            err_report <= 1'b0;
            resync_evt <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            sync_q     <= sync_n;
            err_report <= err_c;
            resync_evt <= resync_c;
            if (!active || sync_q || resync_c) begin
                low_cnt <= '0;
            end else if (low_cnt < CNT_W'(RESYNC_CYCLES)) begin
                low_cnt <= low_cnt + CNT_W'(1);
            end
            if (err_c && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: rtl/jesd204b_dl_tx_link_ctrl.sv
// JESD204B transmit link-state controller: CGS -> ILAS -> DATA sequencing driven
// by SYNC~ and the LMFC pulse, with resync and disable handling.
module jesd204b_dl_tx_link_ctrl
    import jesd204b_dl_pkg::*;
#(
    parameter int unsigned OCTETS_PER_FR  = 5,
    parameter int unsigned FRAMES_PER_MF  = 5,
    parameter int unsigned ILAS_MF        = 4,
    parameter int unsigned OCTET_PER_SENT = 4
) (
    input logic                        clk,
    input logic                        reset,
    jesd204b_dl_tx_link_ctrl_if.slave  bus
);

    localparam int unsigned RESYNC_CYCLES = resync_cycles(OCTETS_PER_FR, OCTET_PER_SENT);

    if (OCTETS_PER_FR < 1 || OCTETS_PER_FR > 256 || FRAMES_PER_MF < 1
        || ILAS_MF < 1 || ILAS_MF > 15 || OCTET_PER_SENT < 1) begin : g_bad_param
        $error("jesd204b_dl_tx_link_ctrl: parameter out of range");
    end

    link_state_e state, state_d;
    logic [3:0]  ilas_mf_d;
    logic        mark_d;
    logic        sync_q;
    logic        resync_c;
    logic        active;

    assign active = bus.enable && ((state == LS_ILAS) || (state == LS_DATA));

    jesd204b_dl_sync_monitor #(
        .RESYNC_CYCLES (RESYNC_CYCLES)
    ) u_sync_monitor (
        .clk        (clk),
        .reset      (reset),
        .sync_n     (bus.sync_n),
        .active     (active),
        .sync_q     (sync_q),
        .resync_c   (resync_c),
        .err_report (bus.err_report),
        .resync_evt (bus.resync_evt),
        .err_count  (bus.err_count)
    );

    // State register; every output is registered from the next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= LS_DISABLED;
            bus.link_state <= 2'b00;
            bus.cgs_en     <= 1'b0;
            bus.ilas_en    <= 1'b0;
            bus.data_en    <= 1'b0;
            bus.ilas_mf    <= 4'd0;
            bus.ilas_cfg   <= 1'b0;
            bus.mark_start <= 1'b0;
        end else begin
            state          <= state_d;
            bus.link_state <= state_d;
            bus.cgs_en     <= (state_d == LS_CGS);
            bus.ilas_en    <= (state_d == LS_ILAS);
            bus.data_en    <= (state_d == LS_DATA);
            bus.ilas_mf    <= ilas_mf_d;
            bus.ilas_cfg   <= (state_d == LS_ILAS) && (ilas_mf_d == 4'd1);
            bus.mark_start <= mark_d;
        end
    end

    // Next-state logic; disable outranks everything, resync outranks LMFC.
    always_comb begin
        state_d   = state;
        ilas_mf_d = bus.ilas_mf;
        mark_d    = 1'b0;
        if (!bus.enable) begin
            state_d   = LS_DISABLED;
            ilas_mf_d = 4'd0;
        end else begin
            case (state)
                LS_DISABLED: state_d = LS_CGS;
                LS_CGS: begin
                    if (sync_q && bus.lmfc) begin
                        state_d   = LS_ILAS;
                        ilas_mf_d = 4'd0;
                        mark_d    = 1'b1;
                    end
                end
                LS_ILAS: begin
                    if (resync_c) begin
                        state_d   = LS_CGS;
                        ilas_mf_d = 4'd0;
                    end else if (bus.lmfc) begin
                        if (bus.ilas_mf == 4'(ILAS_MF - 1)) begin
                            state_d   = LS_DATA;
                            ilas_mf_d = 4'd0;
                        end else begin
                            ilas_mf_d = bus.ilas_mf + 4'd1;
                        end
                    end
                end
                LS_DATA: begin
                    if (resync_c) begin
                        state_d   = LS_CGS;
                        ilas_mf_d = 4'd0;
                    end
                end
                default: state_d = LS_DISABLED;
            endcase
        end
    end

endmodule

// File: doc/jesd204b_dl_tx_link_ctrl.md
Name: jesd204b_dl_tx_link_ctrl

Overview:
- Transmit-side link-state controller for the JESD204B data link layer, one instance per link.
- Sequences each lane through the standard phases: code-group sync (CGS), then the initial lane alignment sequence (ILAS), then user data.
- Decision inputs: the receiver's SYNC~ request and the local multiframe clock (LMFC) pulse.
- Drives the frame/multiframe marker start, the per-lane character-source selects and the ILAS multiframe index. Monitors SYNC~ for error reports and resync requests.

Parameters:
- OCTETS_PER_FR, 5: octets per frame (F), 1..256.
- FRAMES_PER_MF, 5: frames per multiframe (K). Informational only; not used in arithmetic.
- ILAS_MF, 4: multiframes in ILAS, 1..15.
- OCTET_PER_SENT, 4: octets per lane per clk.
- RESYNC_CYCLES, localparam = ceil((5*OCTETS_PER_FR+9)/OCTET_PER_SENT). Default is 9.

Ports:
- clk  in  1  link clock
- reset  in  1  synchronous, active-high
- enable  in  1  link enable; 0 forces DISABLED
- sync_n  in  1  SYNC~ from receiver, active-low, already synchronous to clk
- lmfc  in  1  one-cycle pulse on first beat of each LMFC period
- link_state  out  2  00 DISABLED, 01 CGS, 10 ILAS, 11 DATA
- cgs_en  out  1  lanes transmit /K/ (K28.5)
- ilas_en  out  1  lanes transmit ILAS
- data_en  out  1  lanes transmit scrambled/aligned user data
- ilas_mf  out  4  current ILAS multiframe index
- ilas_cfg  out  1  high while ilas_mf==1 (link-config multiframe)
- mark_start  out  1  one-cycle pulse; frame marker begins marking
- err_report  out  1  one-cycle pulse; short SYNC~ low (error report)
- resync_evt  out  1  one-cycle pulse; resync request accepted
- err_count  out  8  saturating count of err_report pulses

Behaviour:
- Reset values:
  - state = DISABLED.
  - All enables, pulses, ilas_mf and err_count = 0.
  - Internal sync_q = 1, low_cnt = 0.
- sync_q is sync_n registered once. All decisions use sync_q, giving 1 cycle of latency from sync_n.
- All outputs are registered. cgs_en, ilas_en, data_en and link_state are one-hot/decoded from the state register and change in the same cycle as the state.
- enable==0 in any state: DISABLED on the next cycle. This has priority over every other transition. low_cnt and ilas_mf are cleared; err_count is held.
- DISABLED:
  - enable==1 → CGS.
- CGS:
  - sync_q==1 && lmfc==1 → ILAS, with ilas_mf=0 and mark_start=1 on the entry cycle.
  - sync_q==0 is normal in CGS; low_cnt is held at 0.
  - lmfc with sync_q==0: stay in CGS.
- ILAS:
  - Each lmfc pulse: if ilas_mf==ILAS_MF-1 → DATA, ilas_mf=0; else ilas_mf+1.
  - The entry LMFC is not counted, so ILAS lasts exactly ILAS_MF LMFC periods.
  - The DATA transition aligns with an LMFC boundary.
- DATA:
  - Holds until a resync or disable.
- SYNC~ monitor, active in ILAS and DATA:
  - While sync_q==0, low_cnt increments, saturating at RESYNC_CYCLES.
  - When low_cnt reaches RESYNC_CYCLES: CGS on the next cycle, resync_evt=1 for one cycle, ilas_mf=0.
  - On a sync_q rising edge with 1 ≤ low_cnt < RESYNC_CYCLES: err_report=1 for one cycle, err_count+1 (saturates at 255), state unchanged.
  - low_cnt clears on sync_q==1.
- Simultaneous events:
  - lmfc on the same cycle as resync: resync wins.
  - lmfc and the final ILAS pulse on the same cycle as an err_report: both take effect.
- The controller makes no assumption about LMFC period; the lmfc input defines it. A missing LMFC holds the current state indefinitely.
- A reset mid-ILAS or mid-DATA returns to DISABLED on the next edge. No pulse is emitted.

Decomposition:
- Shared package jesd204b_dl_pkg:
  - link-state encoding constants (DISABLED/CGS/ILAS/DATA);
  - K28.5 (8'hBC) and ILAS /R/ /A/ /Q/ constants;
  - RESYNC_CYCLES computation function.
- One sub-module: jesd204b_dl_sync_monitor. It contains the sync_n register, low_cnt, err_report, resync_evt and err_count. The top level keeps the state machine and ILAS counter.

Test Plan (bench drives lmfc every 8 cycles, F=5, ILAS_MF=4):
- Reset, then enable=1 with sync_n=0 for 40 cycles → link_state=01, cgs_en=1, no mark_start.
- sync_n→1, next lmfc → ILAS with mark_start pulse on the entry cycle. ilas_mf sequences 0,1,2,3 at 8-cycle steps; ilas_cfg is high only during ilas_mf=1. DATA is reached exactly 32 cycles after entry.
- In DATA, sync_n low for 3 cycles → err_report single pulse after the rise, err_count=1, data_en stays 1.
- In DATA, sync_n low for 9 cycles → resync_evt pulse, CGS, then ILAS again only at the first lmfc after sync_n returns high.
- enable→0 mid-ILAS (ilas_mf=2) → DISABLED next cycle, ilas_mf=0. Re-enable restarts at CGS.
- Error saturation and priority:
  - 260 short-low events → err_count saturates at 255.
  - lmfc coincident with the 9th low cycle in ILAS → CGS, not an ilas_mf increment.
